// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - eight-entry melody player with tempo select, articulation gaps and looping
// Drives note frequency and mute to the downstream audio divider; start/stop pulses come from the game FSM.
module melody_sequencer #(
  parameter int BEAT_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 2000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  input  logic [1:0]  tempo_sel,
  output logic [10:0] out_frequency,
  output logic        mute,
  output logic        playing,
  output logic [2:0]  note_idx,
  output logic        song_done
);

  // Counter is wide enough for the longest (four-beat) note at the slowest tempo, or the gap.
  localparam int               MAX_LEN   = (4 * BEAT_CYCLES > GAP_CYCLES) ? 4 * BEAT_CYCLES : GAP_CYCLES;
  localparam int               CNT_W     = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] BEAT_FULL = CNT_W'(BEAT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       REST_IDX  = 3'd4;
  localparam logic [2:0]       LAST_IDX  = 3'd7;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       tempo_q;
  logic [10:0]      freq_q;
  logic             mute_q;
  logic             playing_q;
  logic [2:0]       idx_q;
  logic             done_q;

  logic [CNT_W-1:0] beat_len;
  logic [CNT_W-1:0] note_len;
  logic [2:0]       next_idx;

  function automatic logic [10:0] table_freq(input logic [2:0] idx);
    case (idx)
      3'd0:    return 11'd262;
      3'd1:    return 11'd294;
      3'd2:    return 11'd330;
      3'd3:    return 11'd349;
      3'd5:    return 11'd392;
      3'd6:    return 11'd440;
      3'd7:    return 11'd523;
      default: return 11'd1;
    endcase
  endfunction

  // Note lengths are 1, 2 or 4 beats, so the beat product is a left shift.
  function automatic logic [1:0] table_beat_sh(input logic [2:0] idx);
    case (idx)
      3'd5, 3'd6: return 2'd1;
      3'd7:       return 2'd2;
      default:    return 2'd0;
    endcase
  endfunction

  assign beat_len = BEAT_FULL >> tempo_q;
  assign note_len = beat_len << table_beat_sh(idx_q);
  assign next_idx = idx_q + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tempo_q   <= 2'd0;
      freq_q    <= 11'd1;
      mute_q    <= 1'b1;
      playing_q <= 1'b0;
      idx_q     <= 3'd0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        mute_q    <= 1'b1;
        playing_q <= 1'b0;
        idx_q     <= 3'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q   <= PLAY;
              tempo_q   <= tempo_sel;
              cnt_q     <= '0;
              idx_q     <= 3'd0;
              playing_q <= 1'b1;
              freq_q    <= table_freq(3'd0);
              mute_q    <= 1'b0;
            end
          end
          PLAY: begin
            if (cnt_q == note_len - CNT_ONE) begin
              state_q <= GAP;
              cnt_q   <= '0;
              mute_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          GAP: begin
            if (cnt_q == GAP_LAST) begin
              cnt_q <= '0;
              // next_idx wraps 7 -> 0, which is exactly the loop restart entry.
              if (idx_q != LAST_IDX || loop_en) begin
                state_q <= PLAY;
                idx_q   <= next_idx;
                if (next_idx != REST_IDX) begin
                  freq_q <= table_freq(next_idx);
                  mute_q <= 1'b0;
                end
              end else begin
                state_q   <= IDLE;
                idx_q     <= 3'd0;
                playing_q <= 1'b0;
                done_q    <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign out_frequency = freq_q;
  assign mute          = mute_q;
  assign playing       = playing_q;
  assign note_idx      = idx_q;
  assign song_done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - scoreboard bench for melody_sequencer (BEAT_CYCLES=10, GAP_CYCLES=2)
module tb_melody_sequencer;

  localparam int EV_NOTE   = 0;
  localparam int EV_TONE   = 1;
  localparam int EV_DONE   = 2;
  localparam int EV_GLITCH = 3;

  typedef struct {
    int kind;
    int a;
    int b;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [1:0]  tempo_sel = 2'd0;
  logic [10:0] out_frequency;
  logic        mute;
  logic        playing;
  logic [2:0]  note_idx;
  logic        song_done;

  ev_t q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  int exp_freq[8]  = '{262, 294, 330, 349, 349, 392, 440, 523};
  int exp_beats[8] = '{1, 1, 1, 1, 1, 2, 2, 4};

  melody_sequencer #(.BEAT_CYCLES(10), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .tempo_sel(tempo_sel), .out_frequency(out_frequency), .mute(mute),
    .playing(playing), .note_idx(note_idx), .song_done(song_done)
  );

  always #5 clk = ~clk;

  task automatic push(input int kind, input int a, input int b);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b;
    q.push_back(e);
  endtask

  task automatic push_entry(input int i, input int bl, input bit tone_end);
    push(EV_NOTE, i, exp_freq[i] * 2 + ((i == 4) ? 1 : 0));
    if (i != 4 && tone_end) push(EV_TONE, exp_beats[i] * bl, 0);
  endtask

  task automatic push_pass(input int bl);
    for (int i = 0; i < 8; i++) push_entry(i, bl, 1'b1);
  endtask

  task automatic got(input int kind, input int a, input int b);
    ev_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind=%0d a=%0d b=%0d, required no event", kind, a, b);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.a != a || e.b != b) begin
        n_bad++;
        $display("FAIL event_stream: got kind=%0d a=%0d b=%0d, required kind=%0d a=%0d b=%0d",
                 kind, a, b, e.kind, e.a, e.b);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_timeout: %0d expected events still pending, required 0", name, q.size());
      q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_idx(input int idx, input int budget);
    int n = 0;
    while (!(playing && note_idx == 3'(idx)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_note_idx", int'(note_idx), idx);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor: turns the output waveform into note / tone-length / done / glitch events.
  initial begin
    int prev_playing, prev_idx, prev_mute, prev_freq, run_len, cyc;
    prev_playing = 0; prev_idx = 0; prev_mute = 1; prev_freq = 1; run_len = 0; cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_playing = 0; prev_idx = 0; prev_mute = 1; prev_freq = 1; run_len = 0; cyc = 0;
      end else begin
        cyc = (playing && prev_playing == 0) ? 0 : cyc + 1;
        if (playing && (prev_playing == 0 || int'(note_idx) != prev_idx))
          got(EV_NOTE, int'(note_idx), int'(out_frequency) * 2 + int'(mute));
        else if (int'(out_frequency) != prev_freq)
          got(EV_GLITCH, int'(out_frequency), prev_freq);
        if (!mute) run_len++;
        else if (prev_mute == 0) begin
          got(EV_TONE, run_len, 0);
          run_len = 0;
        end
        if (song_done) got(EV_DONE, cyc, int'(playing) * 16 + int'(note_idx) * 2 + int'(mute));
        prev_playing = int'(playing);
        prev_idx     = int'(note_idx);
        prev_mute    = int'(mute);
        prev_freq    = int'(out_frequency);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_freq", int'(out_frequency), 1);
    chk("reset_mute", int'(mute), 1);
    chk("reset_playing", int'(playing), 0);
    chk("reset_note_idx", int'(note_idx), 0);
    chk("reset_song_done", int'(song_done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full song at tempo 0: done 13*10 + 8*2 = 146 cycles after first PLAY cycle.
    push_pass(10);
    push(EV_DONE, 146, 1);
    tempo_sel = 2'd0;
    pulse_start();
    wait_empty("tempo0_song", 400);

    // Tempo 1, with tempo_sel changed and a start pulse issued mid-song.
    push_pass(5);
    push(EV_DONE, 81, 1);
    tempo_sel = 2'd1;
    pulse_start();
    tempo_sel = 2'd3;
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_empty("tempo1_song", 300);

    // Looping: two passes, loop_en cleared during the second.
    push_pass(5);
    push_pass(5);
    push(EV_DONE, 162, 1);
    tempo_sel = 2'd1;
    loop_en = 1'b1;
    pulse_start();
    repeat (120) @(negedge clk);
    loop_en = 1'b0;
    wait_empty("loop_song", 300);

    // Stop in the fifth cycle of entry 5.
    for (int i = 0; i < 5; i++) push_entry(i, 10, 1'b1);
    push(EV_NOTE, 5, 392 * 2);
    push(EV_TONE, 5, 0);
    tempo_sel = 2'd0;
    pulse_start();
    wait_idx(5, 200);
    repeat (4) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_mute", int'(mute), 1);
    chk("stop_playing", int'(playing), 0);
    chk("stop_note_idx", int'(note_idx), 0);
    chk("stop_song_done", int'(song_done), 0);
    wait_empty("stop_flush", 20);

    // Coincident start and stop in IDLE.
    @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("startstop_playing", int'(playing), 0);
    chk("startstop_mute", int'(mute), 1);

    // Asynchronous reset during entry 2.
    push_entry(0, 10, 1'b1);
    push_entry(1, 10, 1'b1);
    push(EV_NOTE, 2, 330 * 2);
    pulse_start();
    wait_idx(2, 100);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_freq", int'(out_frequency), 1);
    chk("async_rst_mute", int'(mute), 1);
    chk("async_rst_playing", int'(playing), 0);
    chk("async_rst_note_idx", int'(note_idx), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_idle_playing", int'(playing), 0);
    chk("post_rst_idle_mute", int'(mute), 1);
    wait_empty("post_rst_flush", 5);

    // Fresh start after reset at tempo 2: done at 13*2 + 16 = 42.
    push_pass(2);
    push(EV_DONE, 42, 1);
    tempo_sel = 2'd2;
    pulse_start();
    wait_empty("after_reset_song", 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
